// File: rtl/nusadc_align_pkg.sv
// Shared types and constants for the ADC serial word aligner.
// Aligner FSM states and the default training word.
package nusadc_align_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEARCH  = 2'd1,
    CONFIRM = 2'd2,
    LOCKED  = 2'd3
  } align_state_t;

  localparam logic [7:0] TRAIN_PATTERN_DEF = 8'hE4;

endpackage

// File: rtl/barrelshift_right_single.sv
// Combinational rotate-right of one word.
// Rotation comes from the low half of a doubled word shifted right.
module barrelshift_right_single #(
  parameter int BIT_SHIFT = 3,
  parameter int N_WORD    = 2**BIT_SHIFT
) (
  input  logic [N_WORD-1:0]    i_data,
  input  logic [BIT_SHIFT-1:0] i_sh,
  output logic [N_WORD-1:0]    o_data
);

  logic [2*N_WORD-1:0] w_dbl;

  assign w_dbl  = {i_data, i_data} >> i_sh;
  assign o_data = w_dbl[N_WORD-1:0];

endmodule

// File: rtl/bitslip_aligner.sv
// Receive word aligner: finds the rotation that yields the training
// word, confirms it, locks it, and streams aligned words.
module bitslip_aligner
  import nusadc_align_pkg::*;
#(
  parameter int                BIT_SHIFT     = 3,
  parameter int                N_WORD        = 2**BIT_SHIFT,
  parameter logic [N_WORD-1:0] TRAIN_PATTERN = N_WORD'(TRAIN_PATTERN_DEF),
  parameter int                LOCK_CNT      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [N_WORD-1:0]    in_data,
  input  logic                 train_req,
  input  logic                 manual_en,
  input  logic [BIT_SHIFT-1:0] manual_sh,
  output logic                 out_valid,
  output logic [N_WORD-1:0]    out_data,
  output logic [BIT_SHIFT-1:0] sh_cur,
  output logic                 locked,
  output logic                 search_fail
);

  localparam int MW = $clog2(LOCK_CNT + 1);

  align_state_t         r_state;
  logic [BIT_SHIFT-1:0] r_sh;
  logic [MW-1:0]        r_match_cnt;
  logic [BIT_SHIFT-1:0] r_try_cnt;
  logic                 r_out_valid;
  logic [N_WORD-1:0]    r_out_data;
  logic                 r_fail;

  logic [BIT_SHIFT-1:0] w_eff_sh;
  logic [N_WORD-1:0]    w_rot_out;
  logic [N_WORD-1:0]    w_rot_cmp;
  logic                 w_match;
  logic                 w_last_try;
  logic [MW-1:0]        w_mc_inc;

  assign w_eff_sh   = manual_en ? manual_sh : r_sh;
  assign w_match    = (w_rot_cmp == TRAIN_PATTERN);
  assign w_last_try = (r_try_cnt == BIT_SHIFT'(N_WORD - 1));
  assign w_mc_inc   = r_match_cnt + MW'(1);

  barrelshift_right_single #(
    .BIT_SHIFT(BIT_SHIFT),
    .N_WORD   (N_WORD)
  ) u_rot_out (
    .i_data(in_data),
    .i_sh  (w_eff_sh),
    .o_data(w_rot_out)
  );

  barrelshift_right_single #(
    .BIT_SHIFT(BIT_SHIFT),
    .N_WORD   (N_WORD)
  ) u_rot_cmp (
    .i_data(in_data),
    .i_sh  (r_sh),
    .o_data(w_rot_cmp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sh        <= '0;
      r_match_cnt <= '0;
      r_try_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_fail      <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid)
        r_out_data <= w_rot_out;

      if (manual_en) begin
        r_state <= IDLE;
      end else if (train_req) begin
        r_state     <= SEARCH;
        r_sh        <= '0;
        r_match_cnt <= '0;
        r_try_cnt   <= '0;
        r_fail      <= 1'b0;
      end else if (in_valid) begin
        unique case (r_state)
          SEARCH, CONFIRM: begin
            if (w_match && r_state == SEARCH) begin
              r_match_cnt <= MW'(1);
              r_state     <= (LOCK_CNT == 1) ? LOCKED : CONFIRM;
            end else if (w_match) begin
              r_match_cnt <= w_mc_inc;
              if (w_mc_inc == MW'(LOCK_CNT))
                r_state <= LOCKED;
            end else begin
              // Reject: next rotation; a full sweep wraps sh back to 0
              r_sh        <= r_sh + BIT_SHIFT'(1);
              r_match_cnt <= '0;
              r_try_cnt   <= r_try_cnt + BIT_SHIFT'(1);
              if (w_last_try) begin
                r_fail  <= 1'b1;
                r_state <= IDLE;
              end else begin
                r_state <= SEARCH;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign sh_cur      = w_eff_sh;
  assign locked      = (r_state == LOCKED) & ~manual_en;
  assign search_fail = r_fail;

endmodule

// File: tb/tb_bitslip_aligner.sv
// Directed self-checking bench for bitslip_aligner.
module tb_bitslip_aligner;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       train_req;
  logic       manual_en;
  logic [2:0] manual_sh;
  logic       out_valid;
  logic [7:0] out_data;
  logic [2:0] sh_cur;
  logic       locked;
  logic       search_fail;

  int n_pass;
  int n_total;

  bitslip_aligner dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .train_req  (train_req),
    .manual_en  (manual_en),
    .manual_sh  (manual_sh),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .sh_cur     (sh_cur),
    .locked     (locked),
    .search_fail(search_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_train();
    train_req = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    #1;
    train_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_total++;
    if ({out_valid, out_data, sh_cur, locked, search_fail} !== 14'd0)
      $display("FAIL reset_outputs got=%h exp=0",
               {out_valid, out_data, sh_cur, locked, search_fail});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'hFF);
    n_total++;
    if (sh_cur !== 3'd0 || out_data !== 8'hFF)
      $display("FAIL reset_idle sh=%0d data=%h exp sh=0 data=ff",
               sh_cur, out_data);
    else n_pass++;
  endtask

  task automatic test_lock();
    pulse_train();
    step(1'b1, 8'h27);
    n_total++;
    if (sh_cur !== 3'd1 || out_data !== 8'h27 || out_valid !== 1'b1)
      $display("FAIL lock_w1 sh=%0d data=%h v=%b exp 1/27/1",
               sh_cur, out_data, out_valid);
    else n_pass++;
    step(1'b1, 8'h27);
    step(1'b1, 8'h27);
    n_total++;
    if (sh_cur !== 3'd3)
      $display("FAIL lock_w3 sh=%0d exp=3", sh_cur);
    else n_pass++;
    for (int k = 4; k <= 7; k++) begin
      step(1'b1, 8'h27);
      n_total++;
      if (out_data !== 8'hE4 || sh_cur !== 3'd3 ||
          locked !== (k == 7))
        $display("FAIL lock_w%0d data=%h sh=%0d lk=%b exp e4/3/%b",
                 k, out_data, sh_cur, locked, k == 7);
      else n_pass++;
    end
    step(1'b0, 8'h00);
    n_total++;
    if (out_valid !== 1'b0 || out_data !== 8'hE4 || locked !== 1'b1)
      $display("FAIL lock_hold v=%b data=%h lk=%b exp 0/e4/1",
               out_valid, out_data, locked);
    else n_pass++;
  endtask

  task automatic test_gapped();
    logic [2:0] exp_sh;
    pulse_train();
    for (int k = 1; k <= 7; k++) begin
      exp_sh = (k <= 3) ? 3'(k) : 3'd3;
      step(1'b1, 8'h27);
      n_total++;
      if (sh_cur !== exp_sh || out_valid !== 1'b1 ||
          locked !== (k == 7))
        $display("FAIL gap_v%0d sh=%0d v=%b lk=%b exp %0d/1/%b",
                 k, sh_cur, out_valid, locked, exp_sh, k == 7);
      else n_pass++;
      step(1'b0, 8'hFF);
      n_total++;
      if (sh_cur !== exp_sh || out_valid !== 1'b0 ||
          locked !== (k == 7))
        $display("FAIL gap_i%0d sh=%0d v=%b lk=%b exp %0d/0/%b",
                 k, sh_cur, out_valid, locked, exp_sh, k == 7);
      else n_pass++;
    end
  endtask

  task automatic test_manual();
    manual_en = 1'b1;
    manual_sh = 3'd6;
    #1;
    n_total++;
    if (locked !== 1'b0 || sh_cur !== 3'd6)
      $display("FAIL man_en lk=%b sh=%0d exp 0/6", locked, sh_cur);
    else n_pass++;
    step(1'b1, 8'h81);
    n_total++;
    if (out_data !== 8'h06)
      $display("FAIL man_data got=%h exp=06", out_data);
    else n_pass++;
    pulse_train();
    manual_en = 1'b0;
    #1;
    n_total++;
    if (sh_cur !== 3'd3 || locked !== 1'b0)
      $display("FAIL man_release sh=%0d lk=%b exp 3/0", sh_cur, locked);
    else n_pass++;
    step(1'b1, 8'hFF);
    n_total++;
    if (sh_cur !== 3'd3)
      $display("FAIL man_idle sh=%0d exp=3", sh_cur);
    else n_pass++;
  endtask

  task automatic test_confirm_fail();
    pulse_train();
    repeat (5) step(1'b1, 8'h27);
    step(1'b1, 8'h00);
    n_total++;
    if (sh_cur !== 3'd4 || locked !== 1'b0 || search_fail !== 1'b0)
      $display("FAIL cf_reject sh=%0d lk=%b sf=%b exp 4/0/0",
               sh_cur, locked, search_fail);
    else n_pass++;
    repeat (3) step(1'b1, 8'h27);
    n_total++;
    if (sh_cur !== 3'd7 || search_fail !== 1'b0)
      $display("FAIL cf_mid sh=%0d sf=%b exp 7/0", sh_cur, search_fail);
    else n_pass++;
    step(1'b1, 8'h27);
    n_total++;
    if (sh_cur !== 3'd0 || search_fail !== 1'b1 || locked !== 1'b0)
      $display("FAIL cf_exhaust sh=%0d sf=%b lk=%b exp 0/1/0",
               sh_cur, search_fail, locked);
    else n_pass++;
  endtask

  task automatic test_sweep();
    pulse_train();
    n_total++;
    if (search_fail !== 1'b0)
      $display("FAIL sw_clear got=%b exp=0", search_fail);
    else n_pass++;
    repeat (7) step(1'b1, 8'hFF);
    n_total++;
    if (sh_cur !== 3'd7 || search_fail !== 1'b0)
      $display("FAIL sw_7 sh=%0d sf=%b exp 7/0", sh_cur, search_fail);
    else n_pass++;
    step(1'b1, 8'hFF);
    n_total++;
    if (sh_cur !== 3'd0 || search_fail !== 1'b1 || locked !== 1'b0)
      $display("FAIL sw_8 sh=%0d sf=%b lk=%b exp 0/1/0",
               sh_cur, search_fail, locked);
    else n_pass++;
    repeat (3) step(1'b1, 8'hFF);
    n_total++;
    if (sh_cur !== 3'd0 || search_fail !== 1'b1)
      $display("FAIL sw_idle sh=%0d sf=%b exp 0/1", sh_cur, search_fail);
    else n_pass++;
    pulse_train();
    n_total++;
    if (search_fail !== 1'b0)
      $display("FAIL sw_retrain sf=%b exp=0", search_fail);
    else n_pass++;
  endtask

  task automatic test_reset_mid_search();
    pulse_train();
    repeat (5) step(1'b1, 8'hFF);
    n_total++;
    if (sh_cur !== 3'd5 || out_valid !== 1'b1)
      $display("FAIL rm_pre sh=%0d v=%b exp 5/1", sh_cur, out_valid);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({out_valid, out_data, sh_cur, locked, search_fail} !== 14'd0)
      $display("FAIL rm_async got=%h exp=0",
               {out_valid, out_data, sh_cur, locked, search_fail});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(1'b1, 8'hFF);
    n_total++;
    if (sh_cur !== 3'd0 || locked !== 1'b0 || search_fail !== 1'b0)
      $display("FAIL rm_idle sh=%0d lk=%b sf=%b exp 0/0/0",
               sh_cur, locked, search_fail);
    else n_pass++;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    train_req = 1'b0;
    manual_en = 1'b0;
    manual_sh = 3'd0;
    test_reset();
    test_lock();
    test_gapped();
    test_manual();
    test_confirm_fail();
    test_sweep();
    test_reset_mid_search();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
